// File: rtl/reg_bank_param_if.sv
// Bus bundle for reg_bank_param: read/write ports, link port, clear handshake, status.
interface reg_bank_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              clr_req;
  logic              clr_busy;
  logic [ADDR_W-1:0] rr1;
  logic [ADDR_W-1:0] rr2;
  logic              mem;
  logic              we;
  logic [ADDR_W-1:0] wr;
  logic [DATA_W-1:0] wdata;
  logic              link_we;
  logic [DATA_W-1:0] link_data;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [DATA_W-1:0] ra;
  logic [DATA_W-1:0] store_data;
  logic              sorted;

  modport master (
    output clr_req, rr1, rr2, mem, we, wr, wdata, link_we, link_data,
    input  clr_busy, rd1, rd2, ra, store_data, sorted
  );

  modport slave (
    input  clr_req, rr1, rr2, mem, we, wr, wdata, link_we, link_data,
    output clr_busy, rd1, rd2, ra, store_data, sorted
  );
endinterface

// File: rtl/reg_bank_param.sv
// KGPRISC general-purpose register file: two read ports, main and link write ports,
// r0 hard-wired to zero, optional write-to-read bypass, sequenced clear engine and a
// registered strictly-increasing flag over a register window.
module reg_bank_param #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int LINK_REG  = 31,
  parameter int CHK_FIRST = 1,
  parameter int CHK_COUNT = 4,
  parameter int BYPASS    = 1
) (
  input logic             clk,
  input logic             rst_n,
  reg_bank_param_if.slave bus
);

  localparam int                 NREGS  = 2**ADDR_W;
  localparam int unsigned        NCMP   = CHK_COUNT - 1;
  localparam logic [ADDR_W-1:0]  LINK_A = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W-1:0]  LAST_A = '1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] regs [NREGS];
  logic              clr_busy_q;
  logic              sorted_q;
  logic              sorted_nxt;
  logic              wr_act;
  logic              link_act;

  // A write is only real when it will commit: not in reset, not during clear, not to r0.
  // The same qualifiers gate the bypass so reads never show data that is being dropped.
  assign wr_act   = bus.we & ~clr_busy_q & rst_n & (bus.wr != '0);
  assign link_act = bus.link_we & ~clr_busy_q & rst_n & (LINK_A != '0);

  function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    if (a == '0)
      v = '0;
    else if ((BYPASS != 0) && link_act && (a == LINK_A))
      v = bus.link_data;
    else if ((BYPASS != 0) && wr_act && (a == bus.wr))
      v = bus.wdata;
    else
      v = regs[a];
    return v;
  endfunction

  assign bus.rd1        = rd_port(bus.mem ? bus.rr2 : bus.rr1);
  assign bus.rd2        = rd_port(bus.rr2);
  assign bus.store_data = rd_port(bus.rr1);
  assign bus.ra         = rd_port(LINK_A);
  assign bus.clr_busy   = clr_busy_q;
  assign bus.sorted     = sorted_q;

  // Window check on stored contents: every neighbour pair strictly increasing (unsigned).
  always_comb begin
    sorted_nxt = 1'b1;
    for (int unsigned i = 0; i < NCMP; i++) begin
      if (!(regs[ADDR_W'(CHK_FIRST + i)] < regs[ADDR_W'(CHK_FIRST + i + 1)]))
        sorted_nxt = 1'b0;
    end
  end

  // Register storage, clear sequencer and sorted flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs       <= '{default: '0};
      state      <= IDLE;
      idx        <= '0;
      clr_busy_q <= 1'b0;
      sorted_q   <= 1'b0;
    end else begin
      sorted_q <= sorted_nxt & ~clr_busy_q;
      case (state)
        IDLE: begin
          if (wr_act)   regs[bus.wr] <= bus.wdata;
          // Later assignment gives the link port priority on a LINK_REG collision.
          if (link_act) regs[LINK_A] <= bus.link_data;
          if (bus.clr_req) begin
            state      <= CLEAR;
            idx        <= '0;
            clr_busy_q <= 1'b1;
          end
        end
        CLEAR: begin
          regs[idx] <= '0;
          if (idx == LAST_A) begin
            state      <= IDLE;
            clr_busy_q <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_param.sv
// Directed bench for reg_bank_param: vector table for reads/writes/bypass/sorted,
// plus hand sequences for async reset, BYPASS=0, clear engine and reset mid-clear.
module tb_reg_bank_param;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_bad = 0;

  reg_bank_param_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  reg_bank_param_if #(.DATA_W(32), .ADDR_W(5)) nb ();

  reg_bank_param #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  reg_bank_param #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .bus(nb.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wdata;
    logic        lwe;
    logic [31:0] ldata;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic        mem;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic [31:0] e_st;
    logic [31:0] e_ra;
    logic        e_sorted;
  } vec_t;

  vec_t vt[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    bus.we = 1'b0; bus.link_we = 1'b0; bus.clr_req = 1'b0; bus.mem = 1'b0;
    bus.wr = '0; bus.wdata = '0; bus.link_data = '0;
  endtask

  // Called at a negedge; returns at the next negedge after the write committed.
  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
    bus.we = 1'b1; bus.wr = a; bus.wdata = d;
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  initial begin
    int c;

    vt[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 32'h0,  5'd5,  5'd0, 1'b0, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0,  1'b0};
    vt[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,  5'd5,  5'd5, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,  1'b0};
    vt[2]  = '{1'b1, 5'd0,  32'h1234,     1'b0, 32'h0,  5'd0,  5'd0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,  1'b0};
    vt[3]  = '{1'b1, 5'd31, 32'h7,        1'b1, 32'h40, 5'd31, 5'd0, 1'b0, 32'h40,       32'h0,        32'h40,       32'h40, 1'b0};
    vt[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,  5'd31, 5'd0, 1'b0, 32'h40,       32'h0,        32'h40,       32'h40, 1'b0};
    vt[5]  = '{1'b1, 5'd31, 32'h7,        1'b0, 32'h0,  5'd31, 5'd5, 1'b0, 32'h7,        32'hDEADBEEF, 32'h7,        32'h7,  1'b0};
    vt[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,  5'd31, 5'd0, 1'b0, 32'h7,        32'h0,        32'h7,        32'h7,  1'b0};
    vt[7]  = '{1'b1, 5'd1,  32'h1,        1'b0, 32'h0,  5'd1,  5'd2, 1'b0, 32'h1,        32'h0,        32'h1,        32'h7,  1'b0};
    vt[8]  = '{1'b1, 5'd2,  32'h2,        1'b0, 32'h0,  5'd1,  5'd2, 1'b0, 32'h1,        32'h2,        32'h1,        32'h7,  1'b0};
    vt[9]  = '{1'b1, 5'd3,  32'h3,        1'b0, 32'h0,  5'd3,  5'd4, 1'b0, 32'h3,        32'h0,        32'h3,        32'h7,  1'b0};
    vt[10] = '{1'b1, 5'd4,  32'h4,        1'b0, 32'h0,  5'd3,  5'd4, 1'b0, 32'h3,        32'h4,        32'h3,        32'h7,  1'b0};
    vt[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,  5'd1,  5'd4, 1'b0, 32'h1,        32'h4,        32'h1,        32'h7,  1'b0};
    vt[12] = '{1'b1, 5'd3,  32'h2,        1'b0, 32'h0,  5'd3,  5'd3, 1'b0, 32'h2,        32'h2,        32'h2,        32'h7,  1'b1};
    vt[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,  5'd3,  5'd0, 1'b0, 32'h2,        32'h0,        32'h2,        32'h7,  1'b1};
    vt[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,  5'd3,  5'd0, 1'b0, 32'h2,        32'h0,        32'h2,        32'h7,  1'b0};
    vt[15] = '{1'b1, 5'd2,  32'h1,        1'b0, 32'h0,  5'd2,  5'd4, 1'b0, 32'h1,        32'h4,        32'h1,        32'h7,  1'b0};
    vt[16] = '{1'b1, 5'd3,  32'h2,        1'b0, 32'h0,  5'd2,  5'd4, 1'b0, 32'h1,        32'h4,        32'h1,        32'h7,  1'b0};
    vt[17] = '{1'b1, 5'd4,  32'h3,        1'b0, 32'h0,  5'd2,  5'd4, 1'b0, 32'h1,        32'h3,        32'h1,        32'h7,  1'b0};
    vt[18] = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,  5'd2,  5'd4, 1'b0, 32'h1,        32'h3,        32'h1,        32'h7,  1'b0};
    vt[19] = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,  5'd2,  5'd4, 1'b0, 32'h1,        32'h3,        32'h1,        32'h7,  1'b0};
    vt[20] = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,  5'd1,  5'd4, 1'b1, 32'h3,        32'h3,        32'h1,        32'h7,  1'b0};

    rst_n = 1'b0;
    idle_in();
    bus.rr1 = '0; bus.rr2 = '0;
    nb.we = 1'b0; nb.link_we = 1'b0; nb.clr_req = 1'b0; nb.mem = 1'b0;
    nb.wr = '0; nb.wdata = '0; nb.link_data = '0; nb.rr1 = '0; nb.rr2 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    bus.rr1 = 5'd7; bus.rr2 = 5'd31;
    #1;
    chk("reset rd1", bus.rd1, 32'h0);
    chk("reset ra", bus.ra, 32'h0);
    chk("reset sorted", {31'b0, bus.sorted}, 32'h0);
    chk("reset clr_busy", {31'b0, bus.clr_busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table: one clock edge per vector
    for (int i = 0; i < 21; i++) begin
      bus.we = vt[i].we; bus.wr = vt[i].wr; bus.wdata = vt[i].wdata;
      bus.link_we = vt[i].lwe; bus.link_data = vt[i].ldata;
      bus.rr1 = vt[i].rr1; bus.rr2 = vt[i].rr2; bus.mem = vt[i].mem;
      #1;
      chk($sformatf("v%0d rd1", i), bus.rd1, vt[i].e_rd1);
      chk($sformatf("v%0d rd2", i), bus.rd2, vt[i].e_rd2);
      chk($sformatf("v%0d store_data", i), bus.store_data, vt[i].e_st);
      chk($sformatf("v%0d ra", i), bus.ra, vt[i].e_ra);
      chk($sformatf("v%0d sorted", i), {31'b0, bus.sorted}, {31'b0, vt[i].e_sorted});
      @(negedge clk);
    end
    idle_in();

    // BYPASS=0 instance: same-cycle read returns the old value
    nb.we = 1'b1; nb.wr = 5'd5; nb.wdata = 32'h11111111;
    @(negedge clk);
    nb.wdata = 32'hDEADBEEF; nb.rr1 = 5'd5;
    #1;
    chk("nobypass old rd1", nb.rd1, 32'h11111111);
    @(negedge clk);
    nb.we = 1'b0;
    #1;
    chk("nobypass new rd1", nb.rd1, 32'hDEADBEEF);

    // Async reset mid-traffic
    wr_reg(5'd2, 32'h2);
    wr_reg(5'd3, 32'h3);
    wr_reg(5'd4, 32'h4);
    @(negedge clk);
    #1;
    chk("pre-reset sorted", {31'b0, bus.sorted}, 32'h1);
    bus.we = 1'b1; bus.wr = 5'd12; bus.wdata = 32'h5;
    bus.link_we = 1'b1; bus.link_data = 32'h88;
    bus.rr1 = 5'd31; bus.rr2 = 5'd12;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst rd1", bus.rd1, 32'h0);
    chk("async rst rd2", bus.rd2, 32'h0);
    chk("async rst store_data", bus.store_data, 32'h0);
    chk("async rst ra", bus.ra, 32'h0);
    chk("async rst sorted", {31'b0, bus.sorted}, 32'h0);
    chk("async rst clr_busy", {31'b0, bus.clr_busy}, 32'h0);
    idle_in();
    @(negedge clk);
    rst_n = 1'b1;
    bus.rr1 = 5'd4;
    #1;
    chk("after rst r4", bus.store_data, 32'h0);

    // Full clear sequence
    for (int k = 1; k < 32; k++) wr_reg(5'(k), 32'h100 + 32'(k));
    @(negedge clk);
    #1;
    chk("pre-clear sorted", {31'b0, bus.sorted}, 32'h1);
    bus.clr_req = 1'b1;
    @(negedge clk);
    bus.clr_req = 1'b0;
    c = 0;
    while (bus.clr_busy === 1'b1 && c < 100) begin
      bus.rr1 = 5'(c - 1); bus.rr2 = 5'(c);
      bus.we = (c == 15); bus.wr = 5'd9; bus.wdata = 32'hFFFF;
      bus.clr_req = (c == 20);
      #1;
      if (c >= 1) begin
        chk($sformatf("clr c%0d reg[c-1]", c), bus.store_data, 32'h0);
        chk($sformatf("clr c%0d reg[c]", c), bus.rd2, 32'h100 + 32'(c));
        chk($sformatf("clr c%0d sorted", c), {31'b0, bus.sorted}, 32'h0);
      end
      @(negedge clk);
      c++;
    end
    idle_in();
    chk("clr busy cycles", 32'(c), 32'd32);
    for (int k = 0; k < 32; k++) begin
      bus.rr1 = 5'(k);
      #1;
      chk($sformatf("cleared r%0d", k), bus.store_data, 32'h0);
    end

    // Reset in the middle of a clear, then a fresh clear restarts at 0
    @(negedge clk);
    wr_reg(5'd10, 32'hAA);
    wr_reg(5'd20, 32'hBB);
    wr_reg(5'd31, 32'hCC);
    bus.clr_req = 1'b1;
    @(negedge clk);
    bus.clr_req = 1'b0;
    c = 0;
    while (bus.clr_busy === 1'b1 && c < 10) begin
      @(negedge clk);
      c++;
    end
    chk("midclr reached idx10", 32'(c), 32'd10);
    bus.rr1 = 5'd20; bus.rr2 = 5'd10;
    #1;
    chk("midclr r20 before rst", bus.store_data, 32'hBB);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midclr rst r20", bus.store_data, 32'h0);
    chk("midclr rst r10", bus.rd2, 32'h0);
    chk("midclr rst ra", bus.ra, 32'h0);
    chk("midclr rst clr_busy", {31'b0, bus.clr_busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post rst clr_busy", {31'b0, bus.clr_busy}, 32'h0);
    @(negedge clk);
    wr_reg(5'd5, 32'h55);
    bus.clr_req = 1'b1;
    @(negedge clk);
    bus.clr_req = 1'b0;
    c = 0;
    while (bus.clr_busy === 1'b1 && c < 100) begin
      bus.rr1 = 5'd5;
      #1;
      if (c == 5) chk("restart r5 still set", bus.store_data, 32'h55);
      if (c == 6) chk("restart r5 cleared", bus.store_data, 32'h0);
      @(negedge clk);
      c++;
    end
    chk("restart busy cycles", 32'(c), 32'd32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
